shreg_mode_sequencer: RTL

Upstream control stage for the 4-bit universal shift register (74194-style) in the lab datapath.
- Drives the register's mode selects S1/S0 and parallel-load data A..D.
- Loads a seed pattern, then issues left shifts until the register's QA..QD outputs return to the seed (period measurement) or a shift limit expires.
- Reports the measured period with a start/busy/done handshake.

---
 rtl/shreg_mode_sequencer_if.sv | 37 +++
 rtl/shreg_mode_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/shreg_mode_sequencer_if.sv
// Control bus between shreg_mode_sequencer and a 74194-style shift register.
// The abort input is present only when SHREG_ABORT_EN is defined.
interface shreg_mode_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [3:0]       seed;
  logic             hold_req;
  logic             QA, QB, QC, QD;
  logic             S1, S0;
  logic             A, B, C, D;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] period;
  logic             timeout;
`ifdef SHREG_ABORT_EN
  logic             abort;

  modport master (
    output start, seed, hold_req, QA, QB, QC, QD, abort,
    input  S1, S0, A, B, C, D, busy, done, period, timeout
  );
  modport slave (
    input  start, seed, hold_req, QA, QB, QC, QD, abort,
    output S1, S0, A, B, C, D, busy, done, period, timeout
  );
`else
  modport master (
    output start, seed, hold_req, QA, QB, QC, QD,
    input  S1, S0, A, B, C, D, busy, done, period, timeout
  );
  modport slave (
    input  start, seed, hold_req, QA, QB, QC, QD,
    output S1, S0, A, B, C, D, busy, done, period, timeout
  );
`endif
endinterface

// File: rtl/shreg_mode_sequencer.sv
// Loads a seed into a 74194-style register and shifts left until Q returns to the seed,
// reporting the period. Optional SHREG_ABORT_EN adds an abort input.
module shreg_mode_sequencer #(
  parameter int CNT_W     = 4,
  parameter int MAX_SHIFT = 15
) (
  input  logic                  clk,
  input  logic                  CLR,
  shreg_mode_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_SHIFT);

  state_t           state;
  logic [3:0]       seed_r;
  logic [CNT_W-1:0] shift_cnt;
  logic [CNT_W-1:0] period_r;
  logic             busy_r;
  logic             done_r;
  logic             timeout_r;

  logic             abort_req;
  logic             match;
  logic             at_limit;
  logic [3:0]       q;
  logic [1:0]       sel;
  logic [3:0]       pdata;

`ifdef SHREG_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  assign q        = {bus.QA, bus.QB, bus.QC, bus.QD};
  // Count 0 always sees the freshly loaded seed, so it is excluded from matching.
  assign match    = (shift_cnt != '0) && (q == seed_r);
  assign at_limit = (shift_cnt == LIMIT);

  // Mode selects must be valid for the same edge the register samples them.
  always_comb begin
    sel   = 2'b00;
    pdata = 4'b0000;
    case (state)
      LOAD: begin
        pdata = seed_r;
        sel   = abort_req ? 2'b00 : 2'b11;
      end
      SHIFT: begin
        if (abort_req || match || at_limit || bus.hold_req) sel = 2'b00;
        else                                                sel = 2'b10;
      end
      default: sel = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      state     <= IDLE;
      seed_r    <= '0;
      shift_cnt <= '0;
      period_r  <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            seed_r    <= bus.seed;
            period_r  <= '0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (abort_req) begin
            period_r  <= '0;
            timeout_r <= 1'b1;
            busy_r    <= 1'b0;
            state     <= IDLE;
          end else begin
            shift_cnt <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort_req) begin
            period_r  <= '0;
            timeout_r <= 1'b1;
            busy_r    <= 1'b0;
            state     <= IDLE;
          end else if (match) begin
            period_r  <= shift_cnt;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            state     <= DONE;
          end else if (at_limit) begin
            period_r  <= '0;
            timeout_r <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            state     <= DONE;
          end else if (!bus.hold_req) begin
            shift_cnt <= shift_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.S1      = sel[1];
  assign bus.S0      = sel[0];
  assign bus.A       = pdata[3];
  assign bus.B       = pdata[2];
  assign bus.C       = pdata[1];
  assign bus.D       = pdata[0];
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.period  = period_r;
  assign bus.timeout = timeout_r;

endmodule
